// File: rtl/host_bfm_tag_pool.sv
// Tag allocator for host BFM non-posted requests: FIFO free list + in-use bitmap.
// Ports: clk/rst (sync, active-high); init_done; alloc_valid/alloc_ready/alloc_tag
// offer; free_valid/free_ready/free_tag return; free_count; err_double_free and
// err_invalid_free one-cycle pulses. HOST_BFM_TAG_POOL_STATS_EN adds alloc_total
// (saturating handshake count) and free_low_water (min free_count since INIT).
module host_bfm_tag_pool #(
  parameter int TAG_WIDTH = 10,
  parameter int NUM_TAGS  = 1024,
  parameter int FIRST_TAG = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 init_done,
  output logic                 alloc_valid,
  input  logic                 alloc_ready,
  output logic [TAG_WIDTH-1:0] alloc_tag,
  input  logic                 free_valid,
  output logic                 free_ready,
  input  logic [TAG_WIDTH-1:0] free_tag,
  output logic [TAG_WIDTH:0]   free_count,
  output logic                 err_double_free,
  output logic                 err_invalid_free
`ifdef HOST_BFM_TAG_POOL_STATS_EN
  ,
  output logic [31:0]          alloc_total,
  output logic [TAG_WIDTH:0]   free_low_water
`endif
);

  localparam int IDX_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam logic [TAG_WIDTH-1:0] FIRST_T = TAG_WIDTH'(FIRST_TAG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAGS - 1);
  localparam logic [TAG_WIDTH:0] NUM_T = (TAG_WIDTH + 1)'(NUM_TAGS);

  if (NUM_TAGS < 2 || NUM_TAGS > 2 ** TAG_WIDTH || FIRST_TAG < 0 ||
      FIRST_TAG + NUM_TAGS - 1 >= 2 ** TAG_WIDTH) begin : g_param_check
    $error("host_bfm_tag_pool: tag range does not fit TAG_WIDTH");
  end

  typedef enum logic {INIT, RUN} state_t;

  state_t               state;
  logic [TAG_WIDTH-1:0] mem [NUM_TAGS];
  logic [IDX_W-1:0]     wr_ptr;
  logic [IDX_W-1:0]     rd_ptr;
  logic [TAG_WIDTH:0]   fifo_cnt;
  logic [NUM_TAGS-1:0]  bitmap;
  logic [NUM_TAGS-1:0]  bitmap_nxt;
  logic                 push_valid;
  logic [TAG_WIDTH-1:0] push_tag;

  logic                 take;
  logic                 fifo_pop;
  logic                 fifo_push;
  logic [TAG_WIDTH-1:0] wr_data;
  logic [TAG_WIDTH:0]   free_off;
  logic [IDX_W-1:0]     free_idx;
  logic [TAG_WIDTH-1:0] alloc_off;
  logic [IDX_W-1:0]     alloc_idx;
  logic                 free_acc;
  logic                 in_range;
  logic                 good_free;

  assign take      = alloc_valid && alloc_ready;
  assign fifo_pop  = (state == RUN) && (fifo_cnt != '0) &&
                     (!alloc_valid || alloc_ready);
  assign fifo_push = (state == INIT) || push_valid;
  assign wr_data   = (state == INIT) ? FIRST_T + TAG_WIDTH'(wr_ptr)
                                     : push_tag;

  // Underflow of the widened offset lands above NUM_TAGS, so one
  // compare covers both ends of the legal range.
  assign free_off  = {1'b0, free_tag} - {1'b0, FIRST_T};
  assign free_idx  = free_off[IDX_W-1:0];
  assign in_range  = free_off < NUM_T;
  assign alloc_off = alloc_tag - FIRST_T;
  assign alloc_idx = alloc_off[IDX_W-1:0];
  assign free_acc  = free_valid && free_ready;
  // Bitmap read before this cycle's alloc set: freeing the tag being
  // handed over right now is a double free.
  assign good_free = free_acc && in_range && bitmap[free_idx];

  always_comb begin
    bitmap_nxt = bitmap;
    if (take)
      bitmap_nxt[alloc_idx] = 1'b1;
    if (good_free)
      bitmap_nxt[free_idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst && fifo_push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= INIT;
      init_done        <= 1'b0;
      alloc_valid      <= 1'b0;
      alloc_tag        <= '0;
      free_ready       <= 1'b0;
      free_count       <= '0;
      err_double_free  <= 1'b0;
      err_invalid_free <= 1'b0;
      bitmap           <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_cnt         <= '0;
      push_valid       <= 1'b0;
      push_tag         <= '0;
    end else begin
      err_invalid_free <= free_acc && !in_range;
      err_double_free  <= free_acc && in_range && !bitmap[free_idx];
      bitmap           <= bitmap_nxt;
      // Returned tags pass through one register before the FIFO.
      push_valid       <= good_free;
      push_tag         <= free_tag;

      if (fifo_push)
        wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
      if (fifo_pop)
        rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;

      if (fifo_push && !fifo_pop)
        fifo_cnt <= fifo_cnt + 1'b1;
      else if (!fifo_push && fifo_pop)
        fifo_cnt <= fifo_cnt - 1'b1;

      if (fifo_pop) begin
        alloc_valid <= 1'b1;
        alloc_tag   <= mem[rd_ptr];
      end else if (take) begin
        alloc_valid <= 1'b0;
      end

      unique case (state)
        INIT: begin
          free_count <= free_count + 1'b1;
          if (wr_ptr == LAST_IDX) begin
            state      <= RUN;
            init_done  <= 1'b1;
            free_ready <= 1'b1;
          end
        end
        RUN: begin
          if (good_free && !take)
            free_count <= free_count + 1'b1;
          else if (take && !good_free)
            free_count <= free_count - 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef HOST_BFM_TAG_POOL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_total    <= '0;
      free_low_water <= NUM_T;
    end else if (state == RUN) begin
      if (take && alloc_total != '1)
        alloc_total <= alloc_total + 1'b1;
      if (free_count < free_low_water)
        free_low_water <= free_count;
    end
  end
`endif

endmodule
